// File: rtl/rv_data_access_sched.sv
// rv_data_access_sched: per-bank scheduler in front of the line-wide single-port cache data store.
//
// After reset, and again after a flush, the scheduler first runs a zeroing sweep over every line.
// Once the sweep is done it grants at most one of two sources per cycle: memory fill responses or
// core read/write requests. Read data is registered into a one-entry response buffer that has
// valid/ready backpressure.
//
// Ports:
//   clk, reset          clock and asynchronous active-low reset
//   flush               one-cycle pulse that restarts the zeroing sweep
//   init_done           high once the sweep is complete and requests are accepted
//   fill_*              memory fill request (valid/ready handshake, line address, full line data)
//   core_*              core request (valid/ready handshake, rw, line, word, byte enables,
//                       write data, tag)
//   rsp_*               read response (valid/ready handshake, tag, data word)
//   da_*                data-store command port; at most one strobe is high per cycle;
//                       da_read_data returns in the same cycle as da_read
module rv_data_access_sched #(
    parameter int unsigned NUM_LINES      = 64,
    parameter int unsigned LINE_SEL_BITS  = 6,
    parameter int unsigned WORDS_PER_LINE = 16,
    parameter int unsigned WORD_SEL_BITS  = 4,
    parameter int unsigned WORD_SIZE      = 4,
    parameter int unsigned TAG_WIDTH      = 8,
    parameter int unsigned FILL_BURST     = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  flush,
    output logic                                  init_done,

    input  logic                                  fill_valid,
    output logic                                  fill_ready,
    input  logic [LINE_SEL_BITS-1:0]              fill_addr,
    input  logic [WORDS_PER_LINE*WORD_SIZE*8-1:0] fill_data,

    input  logic                                  core_valid,
    output logic                                  core_ready,
    input  logic                                  core_rw,
    input  logic [LINE_SEL_BITS-1:0]              core_addr,
    input  logic [WORD_SEL_BITS-1:0]              core_wsel,
    input  logic [WORD_SIZE-1:0]                  core_byteen,
    input  logic [WORD_SIZE*8-1:0]                core_wdata,
    input  logic [TAG_WIDTH-1:0]                  core_tag,

    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [TAG_WIDTH-1:0]                  rsp_tag,
    output logic [WORD_SIZE*8-1:0]                rsp_data,

    output logic                                  da_read,
    output logic                                  da_write,
    output logic                                  da_fill,
    output logic [LINE_SEL_BITS-1:0]              da_addr,
    output logic [WORD_SEL_BITS-1:0]              da_wsel,
    output logic [WORD_SIZE-1:0]                  da_byteen,
    output logic [WORD_SIZE*8-1:0]                da_wdata,
    output logic [WORDS_PER_LINE*WORD_SIZE*8-1:0] da_fill_data,
    input  logic [WORD_SIZE*8-1:0]                da_read_data
);

    localparam int unsigned BURST_W = $clog2(FILL_BURST + 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                   state_q, state_d;
    logic [LINE_SEL_BITS-1:0] sweep_q, sweep_d;
    logic [BURST_W-1:0]       burst_q, burst_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [TAG_WIDTH-1:0]     rsp_tag_q, rsp_tag_d;
    logic [WORD_SIZE*8-1:0]   rsp_data_q, rsp_data_d;

    logic run;
    logic burst_full;
    logic core_ok;
    logic core_elig;
    logic core_gnt;
    logic fill_gnt;

    // Grant logic. Neither ready looks at its own valid, so the consumer may rely on
    // ready being meaningful before it raises valid.
    always_comb begin
        run        = (state_q == StRun);
        burst_full = (burst_q == BURST_W'(FILL_BURST));
        // Writes never produce a response, so only reads wait for buffer space.
        core_ok    = core_rw | ~rsp_valid_q | rsp_ready;
        core_elig  = core_valid & core_ok;

        // reset is folded in so every strobe drops the moment reset is asserted.
        core_ready = reset & run & core_ok & (~fill_valid | burst_full);
        fill_ready = reset & run & ~(core_elig & burst_full);
        core_gnt   = core_valid & core_ready;
        fill_gnt   = fill_valid & fill_ready;

        da_fill    = (reset & ~run) | fill_gnt;
        da_read    = core_gnt & ~core_rw;
        da_write   = core_gnt & core_rw;

        if (!run) begin
            da_addr = sweep_q;
        end else if (fill_gnt) begin
            da_addr = fill_addr;
        end else begin
            da_addr = core_addr;
        end
        da_fill_data = run ? fill_data : '0;
        da_wsel      = core_wsel;
        da_byteen    = core_byteen;
        da_wdata     = core_wdata;
    end

    // Sweep and fill-burst bookkeeping.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        burst_d = burst_q;
        unique case (state_q)
            StInit: begin
                burst_d = '0;
                if (flush) begin
                    sweep_d = '0;
                end else if (sweep_q == LINE_SEL_BITS'(NUM_LINES - 1)) begin
                    state_d = StRun;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + LINE_SEL_BITS'(1);
                end
            end
            StRun: begin
                // The burst counter only measures how long an eligible core request has
                // been passed over by fills.
                if (core_gnt || !core_elig) begin
                    burst_d = '0;
                end else if (fill_gnt) begin
                    burst_d = burst_q + BURST_W'(1);
                end
                if (flush) begin
                    state_d = StInit;
                    sweep_d = '0;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = StInit;
                sweep_d = '0;
                burst_d = '0;
            end
        endcase
    end

    // One-entry response buffer; a drain and a new read in the same cycle keep it full.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_data_d  = rsp_data_q;
        if (da_read) begin
            rsp_valid_d = 1'b1;
            rsp_tag_d   = core_tag;
            rsp_data_d  = da_read_data;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StInit;
            sweep_q     <= '0;
            burst_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            burst_q     <= burst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign init_done = run;
    assign rsp_valid = rsp_valid_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rv_data_access_sched.sv
// Directed bench for rv_data_access_sched. Inputs change just after the falling edge; outputs
// are sampled 1 ns later, well away from the rising edge.
module tb_rv_data_access_sched;

    localparam int LW = 16 * 4 * 8;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          init_done;
    logic          fill_valid;
    logic          fill_ready;
    logic [5:0]    fill_addr;
    logic [LW-1:0] fill_data;
    logic          core_valid;
    logic          core_ready;
    logic          core_rw;
    logic [5:0]    core_addr;
    logic [3:0]    core_wsel;
    logic [3:0]    core_byteen;
    logic [31:0]   core_wdata;
    logic [7:0]    core_tag;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [7:0]    rsp_tag;
    logic [31:0]   rsp_data;
    logic          da_read;
    logic          da_write;
    logic          da_fill;
    logic [5:0]    da_addr;
    logic [3:0]    da_wsel;
    logic [3:0]    da_byteen;
    logic [31:0]   da_wdata;
    logic [LW-1:0] da_fill_data;
    logic [31:0]   da_read_data;

    int vectors    = 0;
    int miscompares = 0;

    rv_data_access_sched dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .init_done    (init_done),
        .fill_valid   (fill_valid),
        .fill_ready   (fill_ready),
        .fill_addr    (fill_addr),
        .fill_data    (fill_data),
        .core_valid   (core_valid),
        .core_ready   (core_ready),
        .core_rw      (core_rw),
        .core_addr    (core_addr),
        .core_wsel    (core_wsel),
        .core_byteen  (core_byteen),
        .core_wdata   (core_wdata),
        .core_tag     (core_tag),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_tag      (rsp_tag),
        .rsp_data     (rsp_data),
        .da_read      (da_read),
        .da_write     (da_write),
        .da_fill      (da_fill),
        .da_addr      (da_addr),
        .da_wsel      (da_wsel),
        .da_byteen    (da_byteen),
        .da_wdata     (da_wdata),
        .da_fill_data (da_fill_data),
        .da_read_data (da_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_phase();
        @(negedge clk);
    endtask

    initial begin
        logic [LW-1:0] pattern;
        pattern = {16{32'hA5A5_0F0F}};

        reset        = 1'b0;
        flush        = 1'b0;
        fill_valid   = 1'b0;
        fill_addr    = '0;
        fill_data    = '0;
        core_valid   = 1'b1;
        core_rw      = 1'b0;
        core_addr    = 6'd5;
        core_wsel    = 4'd3;
        core_byteen  = 4'hF;
        core_wdata   = '0;
        core_tag     = 8'h2A;
        rsp_ready    = 1'b0;
        da_read_data = 32'hDEAD_BEEF;

        // Reset state, with a clock running.
        next_phase();
        next_phase();
        #1;
        check("rst_init_done", init_done, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_da_fill", da_fill, 0);
        check("rst_da_read", da_read, 0);
        check("rst_da_write", da_write, 0);
        check("rst_fill_ready", fill_ready, 0);
        check("rst_core_ready", core_ready, 0);

        // Zeroing sweep: 64 cycles, addresses 0..63, core held off throughout.
        next_phase();
        reset = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1;
            check("sweep_da_fill", da_fill, 1);
            check("sweep_da_addr", da_addr, LW'(i));
            check("sweep_fill_data", da_fill_data, 0);
            check("sweep_core_ready", core_ready, 0);
            check("sweep_init_done", init_done, 0);
            check("sweep_da_read", da_read, 0);
            next_phase();
        end

        // First RUN cycle: the waiting read is granted.
        #1;
        check("run_init_done", init_done, 1);
        check("rd_core_ready", core_ready, 1);
        check("rd_da_read", da_read, 1);
        check("rd_da_fill", da_fill, 0);
        check("rd_da_addr", da_addr, 5);
        check("rd_da_wsel", da_wsel, 3);
        next_phase();
        core_addr    = 6'd7;
        core_tag     = 8'h3C;
        da_read_data = 32'hCAFE_F00D;
        #1;
        check("rsp1_valid", rsp_valid, 1);
        check("rsp1_tag", rsp_tag, 8'h2A);
        check("rsp1_data", rsp_data, 32'hDEAD_BEEF);
        // Buffer full and not draining: second read must wait.
        check("bp_core_ready", core_ready, 0);
        check("bp_da_read", da_read, 0);
        next_phase();
        #1;
        check("hold_rsp_valid", rsp_valid, 1);
        check("hold_rsp_tag", rsp_tag, 8'h2A);
        check("hold_rsp_data", rsp_data, 32'hDEAD_BEEF);
        check("hold_da_read", da_read, 0);
        // Drain cycle: the new read goes through.
        rsp_ready = 1'b1;
        #1;
        check("drain_core_ready", core_ready, 1);
        check("drain_da_read", da_read, 1);
        check("drain_da_addr", da_addr, 7);
        next_phase();
        // Write while the buffer is full and not draining.
        rsp_ready   = 1'b0;
        core_rw     = 1'b1;
        core_addr   = 6'd9;
        core_wsel   = 4'd2;
        core_byteen = 4'b0011;
        core_wdata  = 32'h0000_1234;
        #1;
        check("rsp2_valid", rsp_valid, 1);
        check("rsp2_tag", rsp_tag, 8'h3C);
        check("rsp2_data", rsp_data, 32'hCAFE_F00D);
        check("wr_core_ready", core_ready, 1);
        check("wr_da_write", da_write, 1);
        check("wr_da_read", da_read, 0);
        check("wr_da_addr", da_addr, 9);
        check("wr_da_wsel", da_wsel, 2);
        check("wr_da_byteen", da_byteen, 4'b0011);
        check("wr_da_wdata", da_wdata, 32'h0000_1234);
        next_phase();
        core_valid = 1'b0;
        rsp_ready  = 1'b1;
        #1;
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_tag", rsp_tag, 8'h3C);
        check("wr_rsp_data", rsp_data, 32'hCAFE_F00D);
        next_phase();
        #1;
        check("drained_rsp_valid", rsp_valid, 0);

        // Fill and read both valid: F,F,F,F,C repeating.
        core_valid   = 1'b1;
        core_rw      = 1'b0;
        core_addr    = 6'd1;
        core_tag     = 8'h11;
        da_read_data = 32'h55AA_55AA;
        fill_valid   = 1'b1;
        fill_addr    = 6'h20;
        fill_data    = pattern;
        for (int i = 0; i < 10; i++) begin
            bit c;
            c = (i % 5 == 4);
            #1;
            check("burst_da_fill", da_fill, LW'(!c));
            check("burst_da_read", da_read, LW'(c));
            check("burst_fill_ready", fill_ready, LW'(!c));
            check("burst_core_ready", core_ready, LW'(c));
            check("burst_da_addr", da_addr, c ? LW'(1) : LW'(6'h20));
            if (!c) check("burst_fill_data", da_fill_data, pattern);
            next_phase();
        end

        // Flush in RUN with a fill granted in the same cycle.
        core_valid = 1'b0;
        rsp_ready  = 1'b0;
        flush      = 1'b1;
        #1;
        check("flush_init_done", init_done, 1);
        check("flush_da_fill", da_fill, 1);
        check("flush_fill_ready", fill_ready, 1);
        check("flush_da_addr", da_addr, 6'h20);
        check("flush_rsp_valid", rsp_valid, 1);
        check("flush_rsp_tag", rsp_tag, 8'h11);
        next_phase();
        flush      = 1'b0;
        fill_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("fsweep_init_done", init_done, 0);
            check("fsweep_da_fill", da_fill, 1);
            check("fsweep_da_addr", da_addr, LW'(i));
            check("fsweep_fill_data", da_fill_data, 0);
            check("fsweep_fill_ready", fill_ready, 0);
            next_phase();
        end

        // Asynchronous reset mid-sweep.
        #1;
        reset = 1'b0;
        #1;
        check("areset_da_fill", da_fill, 0);
        check("areset_init_done", init_done, 0);
        check("areset_rsp_valid", rsp_valid, 0);
        check("areset_rsp_data", rsp_data, 0);
        check("areset_rsp_tag", rsp_tag, 0);
        check("areset_fill_ready", fill_ready, 0);
        check("areset_core_ready", core_ready, 0);
        next_phase();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("restart_da_fill", da_fill, 1);
            check("restart_da_addr", da_addr, LW'(i));
            next_phase();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
